sync_fifo_pt: RTL

SYNC_FIFO_PT -- requirements
Module: sync_fifo_pt

---
 rtl/sync_fifo_pt.sv | 104 ++++++++++
 1 files changed

// File: rtl/sync_fifo_pt.sv
// Synchronous FIFO with level/threshold status, ack/error pulses and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module sync_fifo_pt #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH):0]   af_thresh,
  input  logic [$clog2(DEPTH):0]   ae_thresh,
  input  logic                     err_clr,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     rd_valid,
  output logic                     wr_ack,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     ovf_sticky,
  output logic                     udf_sticky,
  output logic                     full,
  output logic                     empty,
  output logic                     almostfull,
  output logic                     almostempty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  rd_acc;
  logic                  wr_acc;

  // A write into a full FIFO is allowed when a read frees a slot on the same edge.
  assign rd_acc = rd_en && (level != '0);
  assign wr_acc = wr_en && ((level < DEPTH_L) || rd_acc);

  assign full        = (level == DEPTH_L);
  assign empty       = (level == '0);
  assign almostfull  = (level >= af_thresh);
  assign almostempty = (level <= ae_thresh);

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      wr_ack     <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= AW'(wr_ptr + AW'(1));
      end
      if (rd_acc) begin
        rd_ptr <= AW'(rd_ptr + AW'(1));
      end
      case ({wr_acc, rd_acc})
        2'b10:   level <= LW'(level + LW'(1));
        2'b01:   level <= LW'(level - LW'(1));
        default: level <= level;
      endcase
      wr_ack    <= wr_acc;
      overflow  <= wr_en && !wr_acc;
      underflow <= rd_en && !rd_acc;
      // A new error on the clearing cycle wins over the clear.
      ovf_sticky <= (wr_en && !wr_acc) || (ovf_sticky && !err_clr);
      udf_sticky <= (rd_en && !rd_acc) || (udf_sticky && !err_clr);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented directly; gated to zero when empty so reset shows zero.
  assign data_out = empty ? '0 : mem[rd_ptr];
  assign rd_valid = !empty;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        data_out <= mem[rd_ptr];
      end
    end
  end
`endif

endmodule
